// File: rtl/filter_cfg_pkg.sv
// Shared types for the filter configuration controller: the packed filter
// configuration word, the controller state encoding, the passthrough constant
// and the button-edit helper.
package filter_cfg_pkg;

  typedef struct packed {
    logic       retro;
    logic       quad;
    logic [1:0] mirror_sel;
  } filter_cfg_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    APPLY   = 2'd2
  } ctrl_state_t;

  localparam filter_cfg_t CFG_PASSTHROUGH = 4'b0000;

  // Apply every button pulse of one cycle together to a configuration word
  function automatic filter_cfg_t apply_buttons(input filter_cfg_t cfg,
                                                input logic        b_mirror,
                                                input logic        b_quad,
                                                input logic        b_retro);
    filter_cfg_t r;
    r = cfg;
    if (b_mirror) r.mirror_sel = cfg.mirror_sel + 2'd1;
    if (b_quad)   r.quad       = ~cfg.quad;
    if (b_retro)  r.retro      = ~cfg.retro;
    return r;
  endfunction

endpackage

// File: rtl/filter_cfg_watchdog.sv
// Timeout counter for the PENDING state. Counts while run is high, clears
// whenever run is low, and pulses expire on the cycle the count reaches
// FRAME_TIMEOUT-1.
module filter_cfg_watchdog #(
  parameter int unsigned FRAME_TIMEOUT = 840000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic expire
);

  localparam int unsigned CW = (FRAME_TIMEOUT > 1) ? $clog2(FRAME_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_TIMEOUT - 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_last;

  assign w_at_last = (r_cnt == LAST);
  assign expire    = run && w_at_last;

  // Count while running; restart on idle or on expiry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!run || w_at_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/filter_cfg_ctrl.sv
// Filter configuration controller. Button and I2C edits land in a shadow
// register; the shadow is committed to the active filter outputs only at a
// frame boundary (or on watchdog timeout) so no frame mixes configurations.
// Optional auto-demo stepping is enabled by defining FILTER_CFG_AUTO_DEMO_EN.
module filter_cfg_ctrl
  import filter_cfg_pkg::*;
#(
  parameter int unsigned FRAME_TIMEOUT = 840000
`ifdef FILTER_CFG_AUTO_DEMO_EN
  ,
  parameter int unsigned DEMO_FRAMES = 120
`endif
) (
  input  logic       clk,
  input  logic       reset,
`ifdef FILTER_CFG_AUTO_DEMO_EN
  input  logic       demo_en,
`endif
  input  logic       frame_start,
  input  logic       btn_mirror,
  input  logic       btn_quad,
  input  logic       btn_retro,
  input  logic       i2c_wr_valid,
  input  logic [3:0] i2c_wr_data,
  output logic       i2c_wr_ready,
  output logic       mode_quad,
  output logic [1:0] mirror_sel,
  output logic       retro_en,
  output logic [3:0] shadow_cfg,
  output logic       cfg_pending,
  output logic       timeout_flag
);

  ctrl_state_t r_state, w_state_nxt;
  filter_cfg_t r_shadow, w_shadow_nxt;
  filter_cfg_t r_active, w_active_nxt;
  logic        r_timeout_flag, w_flag_nxt;

  logic w_i2c_acc;
  logic w_btn_any;
  logic w_btn_acc;
  logic w_edit;
  logic w_expire;
  logic w_demo_step;

  assign w_i2c_acc = i2c_wr_valid && i2c_wr_ready;
  assign w_btn_any = btn_mirror || btn_quad || btn_retro;
  assign w_btn_acc = w_btn_any && (r_state != APPLY);
  assign w_edit    = w_i2c_acc || w_btn_acc;

  filter_cfg_watchdog #(
    .FRAME_TIMEOUT(FRAME_TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .run   (r_state == PENDING),
    .expire(w_expire)
  );

`ifdef FILTER_CFG_AUTO_DEMO_EN
  localparam int unsigned FW = $clog2(DEMO_FRAMES + 1);
  localparam logic [FW-1:0] DEMO_LAST = FW'(DEMO_FRAMES - 1);

  logic [FW-1:0] r_frame_cnt;

  assign w_demo_step = demo_en && (r_state == IDLE) && frame_start &&
                       (r_frame_cnt == DEMO_LAST);

  // Count frames while idle in demo mode; any user edit restarts the count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= '0;
    end else if (!demo_en || w_edit) begin
      r_frame_cnt <= '0;
    end else if ((r_state == IDLE) && frame_start) begin
      r_frame_cnt <= w_demo_step ? '0 : r_frame_cnt + 1'b1;
    end
  end
`else
  assign w_demo_step = 1'b0;
`endif

  // State, shadow, active config and timeout flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_shadow       <= CFG_PASSTHROUGH;
      r_active       <= CFG_PASSTHROUGH;
      r_timeout_flag <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_shadow       <= w_shadow_nxt;
      r_active       <= w_active_nxt;
      r_timeout_flag <= w_flag_nxt;
    end
  end

  // Next-state logic: I2C beats buttons; edits are dropped in APPLY.
  // A timeout that lands with an I2C write still sets the flag.
  always_comb begin
    w_state_nxt  = r_state;
    w_shadow_nxt = r_shadow;
    w_active_nxt = r_active;
    w_flag_nxt   = r_timeout_flag;
    case (r_state)
      IDLE, PENDING: begin
        if (w_i2c_acc) begin
          w_shadow_nxt = i2c_wr_data;
          w_flag_nxt   = 1'b0;
        end else if (w_btn_acc) begin
          w_shadow_nxt = apply_buttons(r_shadow, btn_mirror, btn_quad, btn_retro);
        end else if (w_demo_step) begin
          w_shadow_nxt = 4'(r_shadow) + 4'd1;
        end
        if (r_state == IDLE) begin
          if (w_edit || w_demo_step) w_state_nxt = PENDING;
        end else if (frame_start) begin
          w_state_nxt = APPLY;
        end else if (w_expire) begin
          w_state_nxt = APPLY;
          w_flag_nxt  = 1'b1;
        end
      end
      APPLY: begin
        w_active_nxt = r_shadow;
        w_state_nxt  = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign i2c_wr_ready = (r_state != APPLY);
  assign cfg_pending  = (r_state == PENDING) || (r_state == APPLY);
  assign timeout_flag = r_timeout_flag;
  assign shadow_cfg   = r_shadow;
  assign mode_quad    = r_active.quad;
  assign mirror_sel   = r_active.mirror_sel;
  assign retro_en     = r_active.retro;

endmodule

// File: tb/tb_filter_cfg_ctrl.sv
// Directed bench for filter_cfg_ctrl with FRAME_TIMEOUT=16.
module tb_filter_cfg_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_start = 1'b0;
  logic       btn_mirror = 1'b0;
  logic       btn_quad = 1'b0;
  logic       btn_retro = 1'b0;
  logic       i2c_wr_valid = 1'b0;
  logic [3:0] i2c_wr_data = 4'b0000;
  logic       i2c_wr_ready;
  logic       mode_quad;
  logic [1:0] mirror_sel;
  logic       retro_en;
  logic [3:0] shadow_cfg;
  logic       cfg_pending;
  logic       timeout_flag;
  logic [3:0] active;

  int checks = 0;
  int failures = 0;

  assign active = {retro_en, mode_quad, mirror_sel};

  always #5 clk = ~clk;

  filter_cfg_ctrl #(
    .FRAME_TIMEOUT(16)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
`ifdef FILTER_CFG_AUTO_DEMO_EN
    .demo_en     (1'b0),
`endif
    .frame_start (frame_start),
    .btn_mirror  (btn_mirror),
    .btn_quad    (btn_quad),
    .btn_retro   (btn_retro),
    .i2c_wr_valid(i2c_wr_valid),
    .i2c_wr_data (i2c_wr_data),
    .i2c_wr_ready(i2c_wr_ready),
    .mode_quad   (mode_quad),
    .mirror_sel  (mirror_sel),
    .retro_en    (retro_en),
    .shadow_cfg  (shadow_cfg),
    .cfg_pending (cfg_pending),
    .timeout_flag(timeout_flag)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_active", active, 4'b0000);
    chk("rst_shadow", shadow_cfg, 4'b0000);
    chk("rst_ready", {3'b0, i2c_wr_ready}, 4'd1);
    chk("rst_pending", {3'b0, cfg_pending}, 4'd0);
    chk("rst_tflag", {3'b0, timeout_flag}, 4'd0);

    // Three mirror steps, no frame boundary yet
    btn_mirror = 1'b1;
    tick(); tick(); tick();
    btn_mirror = 1'b0;
    chk("mir_shadow", shadow_cfg, 4'b0011);
    chk("mir_active_held", active, 4'b0000);
    chk("mir_pending", {3'b0, cfg_pending}, 4'd1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("apply_active_not_yet", active, 4'b0000);
    chk("apply_ready_low", {3'b0, i2c_wr_ready}, 4'd0);
    chk("apply_pending", {3'b0, cfg_pending}, 4'd1);
    tick();
    chk("mir_commit", {2'b0, mirror_sel}, 4'b0011);
    chk("mir_commit_pending", {3'b0, cfg_pending}, 4'd0);

    // I2C write collides with btn_quad: I2C wins
    i2c_wr_valid = 1'b1; i2c_wr_data = 4'b1101; btn_quad = 1'b1;
    tick();
    i2c_wr_valid = 1'b0; btn_quad = 1'b0;
    chk("coll_shadow", shadow_cfg, 4'b1101);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    chk("coll_retro", {3'b0, retro_en}, 4'd1);
    chk("coll_quad", {3'b0, mode_quad}, 4'd1);
    chk("coll_mirror", {2'b0, mirror_sel}, 4'b0001);

    // Watchdog: 16 cycles in PENDING without frame_start
    i2c_wr_valid = 1'b1; i2c_wr_data = 4'b0010;
    tick();
    i2c_wr_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("wd_still_pending", {3'b0, i2c_wr_ready}, 4'd1);
    chk("wd_no_flag_yet", {3'b0, timeout_flag}, 4'd0);
    tick();
    chk("wd_apply", {3'b0, i2c_wr_ready}, 4'd0);
    chk("wd_flag", {3'b0, timeout_flag}, 4'd1);
    tick();
    chk("wd_commit", active, 4'b0010);
    chk("wd_idle", {3'b0, cfg_pending}, 4'd0);
    chk("wd_flag_sticky", {3'b0, timeout_flag}, 4'd1);
    i2c_wr_valid = 1'b1; i2c_wr_data = 4'b0110;
    tick();
    i2c_wr_valid = 1'b0;
    chk("wd_flag_cleared", {3'b0, timeout_flag}, 4'd0);
    chk("wd_new_shadow", shadow_cfg, 4'b0110);

    // Valid held across APPLY; button in APPLY is dropped
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    i2c_wr_valid = 1'b1; i2c_wr_data = 4'b1000; btn_retro = 1'b1;
    chk("hold_ready_low", {3'b0, i2c_wr_ready}, 4'd0);
    tick();
    btn_retro = 1'b0;
    chk("hold_ready_back", {3'b0, i2c_wr_ready}, 4'd1);
    chk("hold_active", active, 4'b0110);
    chk("hold_shadow_unchanged", shadow_cfg, 4'b0110);
    chk("hold_idle", {3'b0, cfg_pending}, 4'd0);
    tick();
    i2c_wr_valid = 1'b0;
    chk("hold_accepted", shadow_cfg, 4'b1000);
    chk("hold_pending", {3'b0, cfg_pending}, 4'd1);

    // Reset mid-PENDING with shadow 1111
    i2c_wr_valid = 1'b1; i2c_wr_data = 4'b1111;
    tick();
    i2c_wr_valid = 1'b0;
    chk("pre_rst_shadow", shadow_cfg, 4'b1111);
    reset = 1'b1;
    #1;
    chk("async_rst_active", active, 4'b0000);
    chk("async_rst_shadow", shadow_cfg, 4'b0000);
    chk("async_rst_pending", {3'b0, cfg_pending}, 4'd0);
    tick();
    reset = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    chk("idle_frame_active", active, 4'b0000);
    chk("idle_frame_pending", {3'b0, cfg_pending}, 4'd0);

    // All three buttons in one cycle
    btn_mirror = 1'b1; btn_quad = 1'b1; btn_retro = 1'b1;
    tick();
    btn_mirror = 1'b0; btn_quad = 1'b0; btn_retro = 1'b0;
    chk("allbtn_shadow", shadow_cfg, 4'b1101);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    chk("allbtn_commit", active, 4'b1101);

    // Edit equal to active is still accepted
    i2c_wr_valid = 1'b1; i2c_wr_data = 4'b1101;
    tick();
    i2c_wr_valid = 1'b0;
    chk("same_cfg_pending", {3'b0, cfg_pending}, 4'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
